// File: rtl/cen_pkg.sv
// Shared constants and types for the fractional clock-enable generator.
// Holds the default widths, packing helper and the standard 24 MHz ratios.
package cen_pkg;

    localparam int CEN_ACC_W    = 16;
    localparam int CEN_CHANNELS = 3;

    typedef struct packed {
        logic [CEN_ACC_W-1:0] num;
        logic [CEN_ACC_W-1:0] den;
    } cen_ratio_t;

    // Standard enables derived from a 24 MHz clk_sys
    localparam cen_ratio_t CEN6  = '{num: 16'd1, den: 16'd4};
    localparam cen_ratio_t CEN12 = '{num: 16'd1, den: 16'd2};
    localparam cen_ratio_t CEN2  = '{num: 16'd1, den: 16'd12};

    // LSB position of channel ch inside a packed num/den bus
    function automatic int cen_lsb(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/cen_fracdiv_chan.sv
// One fractional clock-enable accumulator channel.
// Ports: clk_sys/reset, i_num/i_den ratio, i_turbo, i_pause/i_pause_en freeze,
//        i_resync phase clear, o_cen enable pulse, o_cfg_err illegal ratio flag.
module cen_fracdiv_chan
    import cen_pkg::*;
#(
    parameter int ACC_W = CEN_ACC_W
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [ACC_W-1:0] i_num,
    input  logic [ACC_W-1:0] i_den,
    input  logic             i_turbo,
    input  logic             i_pause,
    input  logic             i_pause_en,
    input  logic             i_resync,
    output logic             o_cen,
    output logic             o_cfg_err
);

    logic [ACC_W:0]   r_acc;
    logic             r_cen;
    logic             r_err;

    logic [ACC_W:0]   w_ne;
    logic [ACC_W+1:0] w_den2;
    logic [ACC_W+1:0] w_nxt;
    logic [ACC_W+1:0] w_sub;
    logic [ACC_W:0]   w_acc_step;
    logic             w_step_cen;
    logic             w_bad;
    logic             w_sat;

    always_comb begin
        w_ne       = i_turbo ? {i_num, 1'b0} : {1'b0, i_num};
        w_den2     = {2'b00, i_den};
        w_bad      = (i_den == '0) || (i_num == '0);
        w_sat      = (w_ne >= {1'b0, i_den});
        w_nxt      = {1'b0, r_acc} + {1'b0, w_ne};
        w_step_cen = 1'b0;
        w_sub      = w_nxt;
        if (w_nxt >= w_den2) begin
            w_step_cen = 1'b1;
            w_sub      = w_nxt - w_den2;
        end
        // A den lowered mid-run can leave the residue above the new den;
        // drop it rather than let the accumulator run away.
        w_acc_step = '0;
        if (w_sub < w_den2) begin
            w_acc_step = w_sub[ACC_W:0];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_acc <= '0;
            r_cen <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_bad;
            if (i_resync) begin
                r_acc <= '0;
                r_cen <= 1'b0;
            end else if (i_pause && i_pause_en) begin
                r_cen <= 1'b0;
            end else if (w_bad) begin
                r_acc <= '0;
                r_cen <= 1'b0;
            end else if (w_sat) begin
                r_acc <= '0;
                r_cen <= 1'b1;
            end else begin
                r_acc <= w_acc_step;
                r_cen <= w_step_cen;
            end
        end
    end

    assign o_cen     = r_cen;
    assign o_cfg_err = r_err;

endmodule

// File: rtl/cen_fracdiv.sv
// Multi-channel fractional clock-enable generator (num/den per channel).
// Ports: clk_sys, reset, num/den packed per channel, turbo, pause, pause_mask,
//        resync, cen enable pulses, cfg_err illegal-ratio flags.
module cen_fracdiv
    import cen_pkg::*;
#(
    parameter int CHANNELS = CEN_CHANNELS,
    parameter int ACC_W    = CEN_ACC_W
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [CHANNELS*ACC_W-1:0] num,
    input  logic [CHANNELS*ACC_W-1:0] den,
    input  logic [CHANNELS-1:0]       turbo,
    input  logic                      pause,
    input  logic [CHANNELS-1:0]       pause_mask,
    input  logic                      resync,
    output logic [CHANNELS-1:0]       cen,
    output logic [CHANNELS-1:0]       cfg_err
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        cen_fracdiv_chan #(
            .ACC_W(ACC_W)
        ) u_chan (
            .clk_sys   (clk_sys),
            .reset     (reset),
            .i_num     (num[cen_lsb(i, ACC_W) +: ACC_W]),
            .i_den     (den[cen_lsb(i, ACC_W) +: ACC_W]),
            .i_turbo   (turbo[i]),
            .i_pause   (pause),
            .i_pause_en(pause_mask[i]),
            .i_resync  (resync),
            .o_cen     (cen[i]),
            .o_cfg_err (cfg_err[i])
        );
    end

endmodule

// File: tb/tb_cen_fracdiv.sv
// Directed testbench for cen_fracdiv.
// Hand-computed pulse counts, gaps and flag values per scenario.
module tb_cen_fracdiv;
    import cen_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] num = '0;
    logic [47:0] den = '0;
    logic [2:0]  turbo = '0;
    logic        pause = 1'b0;
    logic [2:0]  pause_mask = '0;
    logic        resync = 1'b0;
    logic [2:0]  cen;
    logic [2:0]  cfg_err;

    int n_chk = 0;
    int n_err = 0;
    int cnt[3];
    int last[3];
    int gmin[3];
    int gmax[3];
    int ec;

    cen_fracdiv #(.CHANNELS(3), .ACC_W(16)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .num       (num),
        .den       (den),
        .turbo     (turbo),
        .pause     (pause),
        .pause_mask(pause_mask),
        .resync    (resync),
        .cen       (cen),
        .cfg_err   (cfg_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_ch(input int ch, input int n, input int d);
        num[ch*16 +: 16] = n[15:0];
        den[ch*16 +: 16] = d[15:0];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic clr();
        ec = 0;
        for (int c = 0; c < 3; c++) begin
            cnt[c]  = 0;
            last[c] = -1;
            gmin[c] = 1 << 30;
            gmax[c] = 0;
        end
    endtask

    task automatic run(input int n);
        int g;
        for (int k = 0; k < n; k++) begin
            tick();
            ec++;
            for (int c = 0; c < 3; c++) begin
                if (cen[c]) begin
                    cnt[c]++;
                    if (last[c] >= 0) begin
                        g = ec - last[c];
                        if (g < gmin[c]) gmin[c] = g;
                        if (g > gmax[c]) gmax[c] = g;
                    end
                    last[c] = ec;
                end
            end
        end
    endtask

    initial begin
        logic [19:0] pat;
        int mm;
        int p;

        // 1: CEN6 from reset, pulses on edges 4,8,12,16,20
        for (int c = 0; c < 3; c++) set_ch(c, CEN6.num, CEN6.den);
        reset = 1'b1;
        tick();
        tick();
        chk("reset_cen", cen, 0);
        chk("reset_err", cfg_err, 0);
        reset = 1'b0;
        pat = '0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            pat[e-1] = cen[0];
        end
        chk("cen6_pattern", pat, 20'h88888);

        // 2: CEN2 with/without turbo, CEN12
        set_ch(0, CEN2.num, CEN2.den);
        set_ch(1, CEN2.num, CEN2.den);
        set_ch(2, CEN12.num, CEN12.den);
        turbo = 3'b001;
        do_reset();
        clr();
        run(1200);
        chk("turbo_cnt", cnt[0], 200);
        chk("plain_cnt", cnt[1], 100);
        chk("cen12_cnt", cnt[2], 600);
        chk("turbo_gmin", gmin[0], 6);
        chk("turbo_gmax", gmax[0], 6);
        chk("plain_gmin", gmin[1], 12);
        chk("plain_gmax", gmax[1], 12);

        // 3: 5/12 fractional, turbo 10/12, saturating 3/2
        set_ch(0, 5, 12);
        set_ch(1, 5, 12);
        set_ch(2, 3, 2);
        turbo = 3'b010;
        do_reset();
        clr();
        run(1200);
        chk("frac_cnt", cnt[0], 500);
        chk("frac_gmin", gmin[0], 2);
        chk("frac_gmax", gmax[0], 3);
        chk("frac_turbo_cnt", cnt[1], 1000);
        chk("sat_cnt", cnt[2], 1200);
        chk("sat_gmax", gmax[2], 1);
        turbo = '0;

        // 4: pause masked on ch0 only, edges 11..17
        set_ch(0, 1, 4);
        set_ch(1, 1, 4);
        set_ch(2, 1, 4);
        do_reset();
        clr();
        run(10);
        chk("pre_pause_ch0", cnt[0], 2);
        p = cnt[1];
        pause = 1'b1;
        pause_mask = 3'b001;
        clr();
        run(7);
        chk("in_pause_ch0", cnt[0], 0);
        chk("in_pause_ch1", cnt[1], 2);
        p += cnt[1];
        pause = 1'b0;
        clr();
        run(2);
        chk("resume_edge19", cen[0], 1);
        run(21);
        chk("post_pause_ch0", cnt[0], 6);
        chk("total_ch1", p + cnt[1], 10);
        pause_mask = '0;

        // 5: den=0 / num=0 error flags and recovery
        do_reset();
        run(5);
        set_ch(2, 1, 0);
        tick();
        chk("den0_err", cfg_err, 3'b100);
        chk("den0_cen", cen[2], 0);
        clr();
        run(8);
        chk("den0_quiet", cnt[2], 0);
        set_ch(2, 1, 4);
        clr();
        run(1);
        chk("den_restore_err", cfg_err, 0);
        run(11);
        chk("den_restore_cnt", cnt[2], 3);
        set_ch(1, 0, 4);
        tick();
        chk("num0_err", cfg_err, 3'b010);
        chk("num0_cen", cen[1], 0);
        set_ch(1, 1, 4);

        // 6: resync beats pause and phase-aligns channels
        do_reset();
        pause = 1'b1;
        pause_mask = 3'b010;
        run(2);
        pause = 1'b0;
        run(3);
        pause = 1'b1;
        pause_mask = 3'b111;
        resync = 1'b1;
        tick();
        chk("resync_cen", cen, 0);
        resync = 1'b0;
        pause = 1'b0;
        mm = 0;
        p = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (cen[0] != cen[1]) mm++;
            if (cen[0]) p++;
        end
        chk("phase_mismatch", mm, 0);
        chk("phase_cnt", p, 3);

        // saturation, resync gap, mid-run reset
        set_ch(0, 3, 2);
        set_ch(1, 3, 2);
        set_ch(2, 3, 0);
        tick();
        tick();
        chk("sat_cen", cen, 3'b011);
        chk("sat_err", cfg_err, 3'b100);
        resync = 1'b1;
        tick();
        chk("sat_resync", cen, 0);
        resync = 1'b0;
        tick();
        chk("sat_after", cen, 3'b011);
        reset = 1'b1;
        tick();
        chk("midrst_cen", cen, 0);
        chk("midrst_err", cfg_err, 0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
